fsqrt_issue_ctrl: RTL and testbench
===================================

Name: fsqrt_issue_ctrl

Overview:
- Issue/retire sequencer placed directly upstream of the iterative Newton FP square-root unit.
- Accepts square-root requests (operand, round mode, destination tag) over a valid/ready handshake.
- Drives the unit's operand, rm, fsqrt-start and enable inputs, and tracks its busy/stall through iteration and the 3-stage exponent pipeline drain.
- Captures the 32-bit result and presents it, tagged, to the FP writeback stage over a valid/ready handshake. Single operation outstanding.

Parameters:
- TAG_W, 5, destination register tag width.
- RES_LAT, 3, enabled cycles from busy/stall release until sq_s is valid (exponent pipeline depth); legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clrn  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_d  in  32  IEEE-754 single-precision operand.
- in_rm  in  2  round mode.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  discard the in-flight operation (pipeline redirect).
- sq_d  out  32  operand to the sqrt unit.
- sq_rm  out  2  round mode to the sqrt unit.
- sq_fsqrt  out  1  one-cycle start pulse.
- sq_ena  out  1  sqrt-unit pipeline enable.
- sq_busy  in  1  sqrt unit iterating.
- sq_stall  in  1  sqrt unit stall request.
- sq_s  in  32  sqrt unit result.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts the result.
- out_s  out  32  result.
- out_tag  out  TAG_W  result tag.
- op_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; out_s=0; out_tag=0; sq_d=0; sq_rm=0; sq_fsqrt=0; sq_ena=0; drain counter=0; op_busy=0. Reset mid-operation drops the operation; nothing is emitted.
- IDLE: in_ready=1, sq_ena=0. On in_valid&in_ready, latch in_d into sq_d, in_rm into sq_rm and in_tag into the tag register, then go to ISSUE. sq_d and sq_rm hold until the next accept.
- ISSUE (1 cycle): sq_fsqrt=1, sq_ena=1. Next state is ITER.
- ITER: sq_ena = ~sq_stall. Stay while sq_busy|sq_stall. When both are 0, load counter with RES_LAT-1 and go to DRAIN.
- DRAIN: sq_ena=1. Decrement the counter each cycle. In the cycle the counter equals 0, register sq_s into out_s and the tag into out_tag, then go to DONE.
  - Latency from accept to out_valid = 1 (ISSUE) + ITER cycles + RES_LAT + 1.
- DONE: out_valid=1; out_s and out_tag are stable. On out_ready go to IDLE; out_valid drops the next cycle. in_ready stays 0 in DONE: no overlap of accept and retire, and no back-to-back same-cycle accept.
- flush:
  - In IDLE or DONE: no effect. A DONE result is already committed.
  - In ISSUE, ITER or DRAIN: set the internal discard flag. The sequence completes normally so the sqrt unit's exponent pipeline stays coherent, but the DRAIN exit goes to IDLE without capture and out_valid stays 0.
  - The discard flag clears on entry to IDLE.
  - flush coincident with in_valid in IDLE: the request is accepted normally.
- sq_fsqrt is never asserted outside ISSUE. sq_ena=0 in IDLE and DONE, which freezes the sqrt unit's e1..e3 registers.
- Internal states use a 3-bit encoding: IDLE, ISSUE, ITER, DRAIN, DONE, BYP (BYP is used only with the optional feature).

Optional Feature:
- Macro: FSQRT_SPECIAL_BYPASS_EN.
- Defined: at accept, classify in_d.
  - Special operands are: sign=1 with a nonzero magnitude; exponent 0xFF; or exponent 0 with fraction 0.
  - For a special operand go to BYP instead of ISSUE. BYP lasts 1 cycle with no sq_fsqrt and sq_ena=0.
  - BYP loads out_s with: 0x7FC00000 for negative nonzero, NaN, or -inf; 0x7F800000 for +inf; the operand itself for +0/-0 (sign preserved). Then go to DONE.
  - Accept-to-out_valid latency is 2 cycles. flush during BYP discards the result.
- Undefined: BYP is unreachable and every operand goes through the sqrt unit. A -0 operand then returns the unit's NaN.

Test Plan:
- Basic: accept in_d=0x41100000 (9.0), rm=0, tag=5; sqrt model holds busy 4 cycles, RES_LAT=3 -> exactly one sq_fsqrt pulse; out_valid after 1+5+3+1 cycles with out_s=0x40400000 and out_tag=5.
- Backpressure: 0x40800000 (4.0) with out_ready=0 for 6 cycles -> out_valid, out_s=0x40000000 and out_tag held stable; in_ready=0 throughout; IDLE one cycle after out_ready=1.
- Stall: sq_stall high for 3 cycles in ITER -> sq_ena=0 for exactly those 3 cycles; result still 0x40000000.
- Flush: flush pulsed in ITER -> no out_valid; in_ready returns 1 after DRAIN completes; the next request (9.0, tag 2) returns 0x40400000 with tag 2.
- Reset: clrn low in DRAIN -> all outputs at reset values immediately; no output after release.
- Bypass (FSQRT_SPECIAL_BYPASS_EN): inputs 0xC0800000, 0x7F800000, 0x80000000 -> out_s 0x7FC00000, 0x7F800000, 0x80000000, each valid 2 cycles after accept with no sq_fsqrt pulse.

Source files
------------

// File: rtl/fsqrt_issue_ctrl_if.sv
// Request/result bundle between the FP issue logic, the sqrt issue controller
// and the FP writeback stage.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. The sender holds valid and its payload
// stable until that edge. The receiver may raise or drop ready freely.
interface fsqrt_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_d;
    logic [1:0]       in_rm;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_s;
    logic [TAG_W-1:0] out_tag;

    // Issue side and writeback side: sends requests and consumes results.
    modport master (
        output in_valid, in_d, in_rm, in_tag, out_ready,
        input  in_ready, out_valid, out_s, out_tag
    );

    // Controller side.
    modport slave (
        input  in_valid, in_d, in_rm, in_tag, out_ready,
        output in_ready, out_valid, out_s, out_tag
    );
endinterface

// File: rtl/fsqrt_issue_ctrl.sv
// Issue/retire sequencer in front of the iterative Newton FP square-root unit.
// It accepts one request, starts the unit, follows busy/stall and the
// RES_LAT-deep exponent pipeline drain, then holds the tagged result until
// writeback takes it. Only one operation is outstanding at a time.
//
// Optional macro FSQRT_SPECIAL_BYPASS_EN: special operands (negative nonzero,
// NaN, +/-inf, +/-0) skip the unit and are answered from the BYP state.
module fsqrt_issue_ctrl #(
    parameter int TAG_W   = 5,
    parameter int RES_LAT = 3
) (
    input  logic               clk,
    input  logic               clrn,
    fsqrt_issue_ctrl_if.slave  bus,
    input  logic               flush,
    output logic [31:0]        sq_d,
    output logic [1:0]         sq_rm,
    output logic               sq_fsqrt,
    output logic               sq_ena,
    input  logic               sq_busy,
    input  logic               sq_stall,
    input  logic [31:0]        sq_s,
    output logic               op_busy,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ITER  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4,
        BYP   = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       cnt_q;
    logic             discard_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      out_s_q;
    logic [TAG_W-1:0] out_tag_q;

    logic             accept;
    logic             special;
    logic             in_flight;
    logic             drop;

`ifdef FSQRT_SPECIAL_BYPASS_EN
    // Operands whose root is known without iterating.
    function automatic logic is_special(input logic [31:0] d);
        return (d[31] && (d[30:0] != 31'd0)) ||
               (d[30:23] == 8'hFF) ||
               (d[30:0] == 31'd0);
    endfunction

    // Root of a special operand: +inf stays +inf, zeros keep their sign,
    // everything else (negative, NaN, -inf) becomes the canonical qNaN.
    function automatic logic [31:0] byp_result(input logic [31:0] d);
        if (d == 32'h7F80_0000)
            return 32'h7F80_0000;
        else if (d[30:0] == 31'd0)
            return d;
        else
            return 32'h7FC0_0000;
    endfunction

    assign special = is_special(bus.in_d);
`else
    assign special = 1'b0;
`endif

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign in_flight = (state_q == ISSUE) || (state_q == ITER) ||
                       (state_q == DRAIN) || (state_q == BYP);
    // A flush in the exit cycle itself must also suppress the capture.
    assign drop      = discard_q || flush;

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = special ? BYP : ISSUE;
            ISSUE: state_d = ITER;
            ITER:  if (!sq_busy && !sq_stall) state_d = DRAIN;
            DRAIN: if (cnt_q == 3'd0) state_d = drop ? IDLE : DONE;
            BYP:   state_d = drop ? IDLE : DONE;
            DONE:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand/tag capture, drain counter, discard flag and result capture.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sq_d      <= 32'd0;
            sq_rm     <= 2'd0;
            tag_q     <= '0;
            cnt_q     <= 3'd0;
            discard_q <= 1'b0;
            out_s_q   <= 32'd0;
            out_tag_q <= '0;
        end else begin
            if (accept) begin
                sq_d  <= bus.in_d;
                sq_rm <= bus.in_rm;
                tag_q <= bus.in_tag;
            end

            if ((state_q == ITER) && (state_d == DRAIN))
                cnt_q <= 3'(RES_LAT - 1);
            else if ((state_q == DRAIN) && (cnt_q != 3'd0))
                cnt_q <= cnt_q - 3'd1;

            if (state_d == IDLE)
                discard_q <= 1'b0;
            else if (flush && in_flight)
                discard_q <= 1'b1;

            if ((state_q == DRAIN) && (cnt_q == 3'd0) && !drop) begin
                out_s_q   <= sq_s;
                out_tag_q <= tag_q;
            end
`ifdef FSQRT_SPECIAL_BYPASS_EN
            if ((state_q == BYP) && !drop) begin
                out_s_q   <= byp_result(sq_d);
                out_tag_q <= tag_q;
            end
`endif
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_s     = out_s_q;
        bus.out_tag   = out_tag_q;
        sq_fsqrt      = (state_q == ISSUE);
        sq_ena        = 1'b0;
        case (state_q)
            ISSUE:   sq_ena = 1'b1;
            ITER:    sq_ena = !sq_stall;
            DRAIN:   sq_ena = 1'b1;
            default: sq_ena = 1'b0;
        endcase
        op_busy   = (state_q != IDLE);
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Directed bench for fsqrt_issue_ctrl with a behavioural stand-in for the
// Newton sqrt unit: busy for busy_len cycles after the start pulse, then the
// result appears on sq_s only after exactly RES_LAT enabled, unstalled cycles.
module tb_fsqrt_issue_ctrl;
    localparam int TAG_W   = 5;
    localparam int RES_LAT = 3;
    localparam int W       = 32 + TAG_W;

    // Clock and reset.
    logic clk;
    logic clrn;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        flush;
    logic [31:0] sq_d;
    logic [1:0]  sq_rm;
    logic        sq_fsqrt;
    logic        sq_ena;
    logic        sq_busy;
    logic        sq_stall;
    logic [31:0] sq_s;
    logic        op_busy;
    logic [2:0]  dbg_state;

    fsqrt_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    fsqrt_issue_ctrl #(.TAG_W(TAG_W), .RES_LAT(RES_LAT)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .bus       (bus),
        .flush     (flush),
        .sq_d      (sq_d),
        .sq_rm     (sq_rm),
        .sq_fsqrt  (sq_fsqrt),
        .sq_ena    (sq_ena),
        .sq_busy   (sq_busy),
        .sq_stall  (sq_stall),
        .sq_s      (sq_s),
        .op_busy   (op_busy),
        .dbg_state (dbg_state)
    );

    // Sqrt unit stand-in.
    int          busy_len;
    logic [31:0] model_res;
    int          busy_cnt;
    int          pipe_cnt;
    logic        run;
    int          fsqrt_pulses = 0;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            busy_cnt <= 0;
            pipe_cnt <= 0;
            run      <= 1'b0;
        end else if (sq_fsqrt) begin
            busy_cnt     <= busy_len;
            pipe_cnt     <= 0;
            run          <= 1'b1;
            fsqrt_pulses <= fsqrt_pulses + 1;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (run && !sq_stall && sq_ena) begin
            pipe_cnt <= pipe_cnt + 1;
        end
    end

    assign sq_busy = (busy_cnt != 0);
    assign sq_s    = (run && pipe_cnt == RES_LAT) ? model_res : 32'hDEAD_BEEF;

    // Scoreboard.
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Driver tasks. Called at a negedge in IDLE; return at the negedge of
    // the cycle after the accept edge (cycle 1).
    task automatic send(input logic [31:0] d, input logic [1:0] rm,
                        input logic [TAG_W-1:0] tag, input logic fl);
        bus.in_valid = 1'b1;
        bus.in_d     = d;
        bus.in_rm    = rm;
        bus.in_tag   = tag;
        flush        = fl;
        #1;
        check("in_ready_at_accept", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        #1;
    endtask

    // Waits (bounded) for out_valid starting at cycle 'start', then checks
    // the accept-to-valid latency and the tagged result against the queue.
    task automatic get_result(input int start, input int exp_lat);
        int cyc;
        logic [63:0] e;
        cyc = start;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 64'(cyc), 64'(exp_lat));
        e = (exp_q.size() != 0) ? 64'(exp_q.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF;
        check("result", 64'({bus.out_tag, bus.out_s}), e);
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

`ifdef FSQRT_SPECIAL_BYPASS_EN
    logic [31:0] byp_in  [3] = '{32'hC080_0000, 32'h7F80_0000, 32'h8000_0000};
    logic [31:0] byp_out [3] = '{32'h7FC0_0000, 32'h7F80_0000, 32'h8000_0000};
`endif

    initial begin
        int   p0;
        logic seen;

        clrn          = 1'b0;
        flush         = 1'b0;
        sq_stall      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_d      = 32'd0;
        bus.in_rm     = 2'd0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        busy_len      = 4;
        model_res     = 32'd0;

        // Reset values.
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_op_busy", 64'(op_busy), 64'd0);
        check("rst_sq_ena", 64'(sq_ena), 64'd0);
        check("rst_sq_fsqrt", 64'(sq_fsqrt), 64'd0);
        check("rst_out_s", 64'(bus.out_s), 64'd0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);

        // Basic: sqrt(9.0) = 3.0, busy 4 -> latency 1+5+3+1.
        busy_len  = 4;
        model_res = 32'h4040_0000;
        exp_q.push_back({5'd5, 32'h4040_0000});
        p0 = fsqrt_pulses;
        send(32'h4110_0000, 2'd0, 5'd5, 1'b0);
        check("basic_fsqrt", 64'(sq_fsqrt), 64'd1);
        check("basic_ena", 64'(sq_ena), 64'd1);
        check("basic_sq_d", 64'(sq_d), 64'h4110_0000);
        check("basic_state", 64'(dbg_state), 64'd1);
        get_result(1, 10);
        check("basic_pulses", 64'(fsqrt_pulses - p0), 64'd1);
        @(negedge clk);
        check("basic_valid_drop", 64'(bus.out_valid), 64'd0);
        check("basic_ready_back", 64'(bus.in_ready), 64'd1);

        // Backpressure: sqrt(4.0) = 2.0 held for 6 cycles with a new request waiting.
        bus.out_ready = 1'b0;
        busy_len      = 3;
        model_res     = 32'h4000_0000;
        exp_q.push_back({5'd9, 32'h4000_0000});
        send(32'h4080_0000, 2'd2, 5'd9, 1'b0);
        check("bp_sq_rm", 64'(sq_rm), 64'd2);
        get_result(1, 9);
        bus.in_valid = 1'b1;
        bus.in_d     = 32'h4110_0000;
        bus.in_tag   = 5'd1;
        repeat (6) begin
            @(negedge clk);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold", 64'({bus.out_tag, bus.out_s}), 64'({5'd9, 32'h4000_0000}));
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        check("bp_sq_d_hold", 64'(sq_d), 64'h4080_0000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle", 64'(op_busy), 64'd0);
        check("bp_valid_drop", 64'(bus.out_valid), 64'd0);

        // Stall: 3 stalled ITER cycles gate sq_ena; latency 1+4+3+1.
        busy_len  = 2;
        model_res = 32'h4000_0000;
        exp_q.push_back({5'd4, 32'h4000_0000});
        send(32'h4080_0000, 2'd0, 5'd4, 1'b0);
        @(negedge clk);
        sq_stall = 1'b1;
        #1;
        check("stall_ena_c2", 64'(sq_ena), 64'd0);
        @(negedge clk);
        check("stall_ena_c3", 64'(sq_ena), 64'd0);
        @(negedge clk);
        check("stall_ena_c4", 64'(sq_ena), 64'd0);
        check("stall_iter_c4", 64'(dbg_state), 64'd2);
        @(negedge clk);
        sq_stall = 1'b0;
        #1;
        check("stall_ena_c5", 64'(sq_ena), 64'd1);
        get_result(5, 9);
        @(negedge clk);

        // Flush in ITER: nothing retires, controller idles after DRAIN.
        busy_len  = 4;
        model_res = 32'h4080_0000;
        send(32'h4180_0000, 2'd0, 5'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen  = 1'b0;
        for (int c = 4; c <= 9; c++) begin
            #1;
            seen = seen | bus.out_valid | bus.in_ready;
            @(negedge clk);
        end
        check("flush_quiet", 64'(seen), 64'd0);
        check("flush_ready_back", 64'(bus.in_ready), 64'd1);
        check("flush_no_valid", 64'(bus.out_valid), 64'd0);

        // Flush coincident with an IDLE accept is ignored.
        model_res = 32'h4040_0000;
        exp_q.push_back({5'd2, 32'h4040_0000});
        send(32'h4110_0000, 2'd0, 5'd2, 1'b1);
        get_result(1, 10);
        @(negedge clk);

        // Reset in DRAIN: outputs return to reset values, nothing retires.
        busy_len  = 2;
        model_res = 32'h4000_0000;
        send(32'h4080_0000, 2'd1, 5'd3, 1'b0);
        repeat (4) @(negedge clk);
        check("rst_mid_in_drain", 64'(dbg_state), 64'd3);
        clrn = 1'b0;
        #1;
        check("rstm_in_ready", 64'(bus.in_ready), 64'd1);
        check("rstm_out_valid", 64'(bus.out_valid), 64'd0);
        check("rstm_out_s", 64'(bus.out_s), 64'd0);
        check("rstm_out_tag", 64'(bus.out_tag), 64'd0);
        check("rstm_sq_d", 64'(sq_d), 64'd0);
        check("rstm_sq_rm", 64'(sq_rm), 64'd0);
        check("rstm_sq_fsqrt", 64'(sq_fsqrt), 64'd0);
        check("rstm_sq_ena", 64'(sq_ena), 64'd0);
        check("rstm_op_busy", 64'(op_busy), 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        check("rstm_no_output", 64'(seen), 64'd0);
        check("rstm_idle", 64'(dbg_state), 64'd0);

`ifdef FSQRT_SPECIAL_BYPASS_EN
        // Special operands answered in 2 cycles without starting the unit.
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({5'(i + 10), byp_out[i]});
            p0 = fsqrt_pulses;
            send(byp_in[i], 2'd0, 5'(i + 10), 1'b0);
            check("byp_fsqrt", 64'(sq_fsqrt), 64'd0);
            check("byp_ena", 64'(sq_ena), 64'd0);
            get_result(1, 2);
            check("byp_pulses", 64'(fsqrt_pulses - p0), 64'd0);
            @(negedge clk);
        end
        // Flush during BYP discards the bypass answer.
        send(32'hFF80_0000, 2'd0, 5'd20, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("byp_flush_valid", 64'(bus.out_valid), 64'd0);
        check("byp_flush_ready", 64'(bus.in_ready), 64'd1);
`else
        // -0 goes through the unit; the unit's NaN is returned.
        busy_len  = 1;
        model_res = 32'h7FC0_0000;
        exp_q.push_back({5'd6, 32'h7FC0_0000});
        p0 = fsqrt_pulses;
        send(32'h8000_0000, 2'd0, 5'd6, 1'b0);
        get_result(1, 7);
        check("negzero_pulses", 64'(fsqrt_pulses - p0), 64'd1);
        @(negedge clk);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
